// File: rtl/impulse_pkg.sv
// impulse_conditioner shared package: default sizes and FSM states.
// Also sizes the optional glitch counter (IMPULSE_COND_GLITCH_CNT_EN).
package impulse_pkg;

  localparam int N_CH_DEF     = 8;
  localparam int FILT_W_DEF   = 3;
  localparam int FILT_LEN_DEF = 4;
  localparam int GLITCH_CNT_W = 8;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/impulse_conditioner_if.sv
// Pad-side and counter-side signal bundle of impulse_conditioner.
// glitch_cnt exists only when IMPULSE_COND_GLITCH_CNT_EN is defined.
interface impulse_conditioner_if #(
  parameter int N_CH = 8
);
  import impulse_pkg::*;

  logic [N_CH-1:0] ch_in;
  logic            enable;
  logic [N_CH-1:0] ch_pulse;
  logic [N_CH-1:0] ch_level;
  logic            any_pulse;
  logic            ready;
`ifdef IMPULSE_COND_GLITCH_CNT_EN
  logic [GLITCH_CNT_W-1:0] glitch_cnt;

  modport master (
    output ch_in, enable,
    input  ch_pulse, ch_level, any_pulse, ready, glitch_cnt
  );

  modport slave (
    input  ch_in, enable,
    output ch_pulse, ch_level, any_pulse, ready, glitch_cnt
  );
`else
  modport master (
    output ch_in, enable,
    input  ch_pulse, ch_level, any_pulse, ready
  );

  modport slave (
    input  ch_in, enable,
    output ch_pulse, ch_level, any_pulse, ready
  );
`endif

endinterface

// File: rtl/impulse_filter_ch.sv
// One impulse channel: 2-flop synchroniser, persistence filter, edge event.
// glitch output exists only with IMPULSE_COND_GLITCH_CNT_EN.
module impulse_filter_ch
  import impulse_pkg::*;
#(
  parameter int FILT_W   = FILT_W_DEF,
  parameter int FILT_LEN = FILT_LEN_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic ch_in,
  input  logic init_load,
  input  logic run,
  output logic level,
  output logic sample,
`ifdef IMPULSE_COND_GLITCH_CNT_EN
  output logic glitch,
`endif
  output logic edge_evt
);

  localparam logic [FILT_W-1:0] LAST =
    FILT_W'(FILT_LEN - 1);

  logic              s1;
  logic              s2;
  logic [FILT_W-1:0] cnt;
  logic              differ;

  assign differ   = s2 != level;
  assign sample   = s2;
  assign edge_evt = run & differ & (cnt == LAST);
`ifdef IMPULSE_COND_GLITCH_CNT_EN
  assign glitch   = run & ~differ & (cnt != '0);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      s1 <= ch_in;
      s2 <= s1;
      // s1 is the value s2 takes on this same edge
      if (init_load) begin
        level <= s1;
        cnt   <= '0;
      end else if (run) begin
        if (!differ) begin
          cnt <= '0;
        end else if (cnt == LAST) begin
          level <= s2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/impulse_conditioner.sv
// Impulse counter front end: per-channel filtering, INIT/RUN FSM, pulses.
// Define IMPULSE_COND_GLITCH_CNT_EN to add the saturating glitch_cnt.
module impulse_conditioner
  import impulse_pkg::*;
#(
  parameter int N_CH      = N_CH_DEF,
  parameter int FILT_W    = FILT_W_DEF,
  parameter int FILT_LEN  = FILT_LEN_DEF,
  parameter bit RISE_EDGE = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  impulse_conditioner_if.slave  bus
);

  state_t          state;
  state_t          state_n;
  logic            init_cnt;
  logic            init_load;
  logic            run;
  logic [N_CH-1:0] level;
  logic [N_CH-1:0] sample;
  logic [N_CH-1:0] edge_evt;
  logic [N_CH-1:0] want;
  logic [N_CH-1:0] pulse_q;
`ifdef IMPULSE_COND_GLITCH_CNT_EN
  logic [N_CH-1:0]         glitch;
  logic [GLITCH_CNT_W-1:0] gcnt;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= INIT;
      init_cnt <= 1'b0;
    end else begin
      state <= state_n;
      if (state == INIT) init_cnt <= 1'b1;
    end
  end

  always_comb begin
    state_n   = state;
    init_load = 1'b0;
    case (state)
      INIT: begin
        if (init_cnt) begin
          init_load = 1'b1;
          state_n   = RUN;
        end
      end
      RUN:     state_n = RUN;
      default: state_n = INIT;
    endcase
  end

  assign run = state == RUN;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    impulse_filter_ch #(
      .FILT_W   (FILT_W),
      .FILT_LEN (FILT_LEN)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .ch_in     (bus.ch_in[i]),
      .init_load (init_load),
      .run       (run),
      .level     (level[i]),
      .sample    (sample[i]),
`ifdef IMPULSE_COND_GLITCH_CNT_EN
      .glitch    (glitch[i]),
`endif
      .edge_evt  (edge_evt[i])
    );
  end

  // sample is the level being accepted on this edge
  assign want = edge_evt
              & (RISE_EDGE ? sample : ~sample)
              & {N_CH{bus.enable}};

  always_ff @(posedge clk) begin
    if (reset) pulse_q <= '0;
    else       pulse_q <= want;
  end

  assign bus.ch_pulse  = pulse_q;
  assign bus.ch_level  = level;
  assign bus.any_pulse = |pulse_q;
  assign bus.ready     = run;

`ifdef IMPULSE_COND_GLITCH_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      gcnt <= '0;
    end else if (run && (|glitch) && (gcnt != '1)) begin
      gcnt <= gcnt + 1'b1;
    end
  end

  assign bus.glitch_cnt = gcnt;
`endif

endmodule

// File: tb/tb_impulse_conditioner.sv
// Scoreboard bench for impulse_conditioner against a history-based model.
// Checks glitch_cnt when IMPULSE_COND_GLITCH_CNT_EN is defined.
module tb_impulse_conditioner;

  localparam int N    = 8;
  localparam int FL   = 4;
  localparam bit RISE = 1'b1;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  impulse_conditioner_if #(.N_CH(N)) bus();

  impulse_conditioner #(
    .N_CH      (N),
    .FILT_W    (3),
    .FILT_LEN  (FL),
    .RISE_EDGE (RISE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [7:0] pulse;
    logic [7:0] level;
    logic       anyp;
    logic       rdy;
    logic [7:0] gc;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // model: inputs seen at each edge since reset, indexed by edge number
  logic [7:0] hist[$];
  int         e = 0;
  logic [7:0] m_level = '0;
  int         last_acc[N];
  int         m_gc = 0;

  function automatic logic [7:0] in_at(int x);
    return hist[x-1];
  endfunction

  task automatic chk(string name, logic [7:0] act, logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, req);
    end
  endtask

  task automatic step(bit rst, bit en, logic [7:0] ch);
    logic [7:0] pulse;
    logic [7:0] v;
    logic [7:0] w;
    bit         g;
    bit         acc;
    exp_t       x;
    @(negedge clk);
    reset      = rst;
    bus.enable = en;
    bus.ch_in  = ch;
    pulse = '0;
    g     = 1'b0;
    if (rst) begin
      e = 0;
      hist.delete();
      m_level = '0;
      m_gc    = 0;
      for (int i = 0; i < N; i++) last_acc[i] = 0;
    end else begin
      e++;
      hist.push_back(ch);
      if (e == 2) begin
        m_level = in_at(1);
        for (int i = 0; i < N; i++) last_acc[i] = 2;
      end else if (e >= 3) begin
        v = in_at(e - 2);
        for (int i = 0; i < N; i++) begin
          acc = 1'b1;
          for (int k = 0; k < FL; k++) begin
            if (e - k <= last_acc[i]) begin
              acc = 1'b0;
            end else begin
              w = in_at(e - k - 2);
              if (w[i] == m_level[i]) acc = 1'b0;
            end
          end
          if (v[i] == m_level[i] && e - 1 > last_acc[i]) begin
            w = in_at(e - 3);
            if (w[i] != m_level[i]) g = 1'b1;
          end
          if (acc) begin
            m_level[i]  = v[i];
            last_acc[i] = e;
            if (v[i] == RISE && en) pulse[i] = 1'b1;
          end
        end
        if (g && m_gc < 255) m_gc++;
      end
    end
    x.pulse = pulse;
    x.level = m_level;
    x.anyp  = |pulse;
    x.rdy   = !rst && e >= 2;
    x.gc    = 8'(m_gc);
    exp_q.push_back(x);
  endtask

  task automatic hold(logic [7:0] ch, int n, bit en = 1'b1);
    repeat (n) step(1'b0, en, ch);
  endtask

  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        chk("ch_pulse", bus.ch_pulse, x.pulse);
        chk("ch_level", bus.ch_level, x.level);
        chk("any_pulse", {7'd0, bus.any_pulse}, {7'd0, x.anyp});
        chk("ready", {7'd0, bus.ready}, {7'd0, x.rdy});
`ifdef IMPULSE_COND_GLITCH_CNT_EN
        chk("glitch_cnt", bus.glitch_cnt, x.gc);
`endif
      end
    end
  end

  initial begin
    logic [7:0] cur;
    bus.enable = 1'b1;
    bus.ch_in  = 8'h05;
    repeat (3) step(1'b1, 1'b1, 8'h05);
    hold(8'h05, 12);
    hold(8'h00, 12);
    hold(8'h04, 12);
    hold(8'h00, 12);
    hold(8'h01, 3);
    hold(8'h00, 8);
    hold(8'h01, 4);
    hold(8'h00, 10);
    hold(8'hFF, 10);
    hold(8'h00, 10);
    hold(8'h20, 10, 1'b0);
    hold(8'h20, 10, 1'b1);
    hold(8'h00, 10);
    cur = 8'h00;
    repeat (1500) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(5) == 0) cur[i] = ~cur[i];
      step($urandom_range(299) == 0,
           $urandom_range(9) != 0, cur);
    end
    repeat (2) step(1'b1, 1'b1, 8'h00);
    hold(8'h00, 5);
    repeat (300) begin
      step(1'b0, 1'b1, 8'h01);
      step(1'b0, 1'b1, 8'h00);
    end
    step(1'b0, 1'b1, 8'h01);
    repeat (2) step(1'b1, 1'b1, 8'h01);
    hold(8'h01, 12);
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d want=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
